// File: rtl/clk_meter_pkg.sv
// ============================================================================
// clk_meter_pkg : shared state encoding and default sizing for clk_period_meter
// Rev 1.0
// ============================================================================
`default_nettype none

package clk_meter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      STALLED = 2'd2
   } state_e;

   // Plain vector encodings of the enum so the state register stays a logic vector
   localparam logic [1:0] ST_IDLE    = 2'(IDLE);
   localparam logic [1:0] ST_MEASURE = 2'(MEASURE);
   localparam logic [1:0] ST_STALLED = 2'(STALLED);

   localparam int unsigned CNT_W_DEF   = 24;
   localparam int unsigned TIMEOUT_DEF = 16777215;
   localparam int unsigned TOL_DEF     = 16;

endpackage

`default_nettype wire

// File: rtl/sync_edge_detect.sv
// ============================================================================
// sync_edge_detect : two-flop synchronizer with history flop and toggle detect
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_edge_detect
   import clk_meter_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic sig_in,
   output logic level,
   output logic edge_pulse
);

   logic s1;
   logic s2;
   logic s3;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= sig_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign level      = s2;
   assign edge_pulse = s2 ^ s3;

endmodule

`default_nettype wire

// File: rtl/clk_period_meter.sv
// ============================================================================
// clk_period_meter : measures half-period of a slow async square wave in clk cycles
// Rev 1.0
// ============================================================================
`default_nettype none

module clk_period_meter
   import clk_meter_pkg::*;
#(
   parameter int unsigned CNT_W   = CNT_W_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF,
   parameter int unsigned TOL     = TOL_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sig_in,
   output logic [CNT_W-1:0] half_period,
   output logic             meas_valid,
   output logic             locked,
   output logic             timeout,
   output logic             level
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

   logic             sig_edge;
   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] prev;
   logic             have_prev;
   logic [CNT_W-1:0] abs_diff;
   logic             within_tol;

   sync_edge_detect u_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .sig_in     (sig_in),
      .level      (level),
      .edge_pulse (sig_edge)
   );

   // Smaller operand is always subtracted from the larger so the result never wraps
   always_comb begin
      abs_diff = '0;
      if (cnt >= prev) begin
         abs_diff = cnt - prev;
      end else begin
         abs_diff = prev - cnt;
      end
      within_tol = (abs_diff <= TOL_C);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         prev        <= '0;
         have_prev   <= 1'b0;
         half_period <= '0;
         meas_valid  <= 1'b0;
         locked      <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (sig_edge) begin
                  state <= ST_MEASURE;
                  cnt   <= ONE;
               end else begin
                  cnt <= '0;
               end
            end
            ST_MEASURE: begin
               // An edge coinciding with cnt == TIMEOUT is a valid full-length interval
               if (sig_edge) begin
                  half_period <= cnt;
                  meas_valid  <= 1'b1;
                  locked      <= have_prev && within_tol;
                  prev        <= cnt;
                  have_prev   <= 1'b1;
                  cnt         <= ONE;
               end else if (cnt == TIMEOUT_C) begin
                  state     <= ST_STALLED;
                  timeout   <= 1'b1;
                  locked    <= 1'b0;
                  have_prev <= 1'b0;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
            ST_STALLED: begin
               // The interval that ends here started before the stall, so it is discarded
               if (sig_edge) begin
                  state   <= ST_MEASURE;
                  timeout <= 1'b0;
                  cnt     <= ONE;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_clk_period_meter.sv
// ============================================================================
// tb_clk_period_meter : scoreboard-based self-checking bench for clk_period_meter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_clk_period_meter;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic       sig_in = 1'b0;
   logic [7:0] half_period;
   logic       meas_valid;
   logic       locked;
   logic       timeout;
   logic       level;

   int passed = 0;
   int total  = 0;

   typedef struct packed {
      logic [7:0] hp;
      logic       lk;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   logic mv_d = 1'b0;

   always #5 clk = ~clk;

   clk_period_meter #(
      .CNT_W   (8),
      .TIMEOUT (20),
      .TOL     (1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sig_in      (sig_in),
      .half_period (half_period),
      .meas_valid  (meas_valid),
      .locked      (locked),
      .timeout     (timeout),
      .level       (level)
   );

   // Every measurement must match the head of the scoreboard and last one cycle
   always @(negedge clk) begin
      if (meas_valid) begin
         total++;
         if (sb.size() == 0) begin
            $display("FAIL unexpected_meas: got half_period=%0d locked=%0d, required no measurement",
                     half_period, locked);
         end else begin
            mon_e = sb.pop_front();
            if (half_period !== mon_e.hp || locked !== mon_e.lk)
               $display("FAIL meas: got half_period=%0d locked=%0d, required half_period=%0d locked=%0d",
                        half_period, locked, mon_e.hp, mon_e.lk);
            else
               passed++;
         end
         total++;
         if (mv_d !== 1'b0)
            $display("FAIL meas_valid_width: got high on consecutive cycles, required single pulse");
         else
            passed++;
      end
      mv_d <= meas_valid;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic toggle_after(input int n);
      tick(n);
      sig_in = ~sig_in;
   endtask

   task automatic push_exp(input int hp, input bit lk);
      exp_t e;
      e.hp = 8'(hp);
      e.lk = lk;
      sb.push_back(e);
   endtask

   task automatic do_reset;
      sig_in = 1'b0;
      rst_n  = 1'b0;
      tick(3);
      rst_n  = 1'b1;
      tick(4);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sig_in = ~sig_in;
         tick(1);
      end
      total++; if (half_period !== 8'd0) $display("FAIL rst_half_period: got %0d, required 0", half_period); else passed++;
      total++; if (meas_valid !== 1'b0) $display("FAIL rst_meas_valid: got %0b, required 0", meas_valid); else passed++;
      total++; if (locked !== 1'b0) $display("FAIL rst_locked: got %0b, required 0", locked); else passed++;
      total++; if (timeout !== 1'b0) $display("FAIL rst_timeout: got %0b, required 0", timeout); else passed++;
      total++; if (level !== 1'b0) $display("FAIL rst_level: got %0b, required 0", level); else passed++;
      rst_n  = 1'b1;
      sig_in = 1'b1;
      tick(4);
      total++; if (level !== 1'b1) $display("FAIL level_after_rst: got %0b, required 1", level); else passed++;
      tick(2);
      sig_in = ~sig_in;
      push_exp(6, 1'b0);
      tick(6);
      total++; if (sb.size() != 0) $display("FAIL reset_pending: got %0d outstanding, required 0", sb.size()); else passed++;
   endtask

   task automatic test_steady;
      do_reset();
      toggle_after(2);
      for (int i = 0; i < 4; i++) begin
         toggle_after(5);
         push_exp(5, i > 0);
      end
      tick(6);
      total++; if (sb.size() != 0) $display("FAIL steady_pending: got %0d outstanding, required 0", sb.size()); else passed++;
   endtask

   task automatic test_jitter;
      int iv[4] = '{5, 5, 8, 8};
      bit lk[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      do_reset();
      toggle_after(2);
      for (int i = 0; i < 4; i++) begin
         toggle_after(iv[i]);
         push_exp(iv[i], lk[i]);
      end
      tick(6);
      total++; if (sb.size() != 0) $display("FAIL jitter_pending: got %0d outstanding, required 0", sb.size()); else passed++;
   endtask

   task automatic test_stall;
      do_reset();
      toggle_after(2);
      toggle_after(5); push_exp(5, 1'b0);
      toggle_after(5); push_exp(5, 1'b1);
      tick(18);
      total++; if (timeout !== 1'b0) $display("FAIL stall_early_timeout: got %0b, required 0", timeout); else passed++;
      total++; if (locked !== 1'b1) $display("FAIL stall_early_locked: got %0b, required 1", locked); else passed++;
      tick(9);
      total++; if (timeout !== 1'b1) $display("FAIL stall_timeout: got %0b, required 1", timeout); else passed++;
      total++; if (locked !== 1'b0) $display("FAIL stall_locked: got %0b, required 0", locked); else passed++;
      total++; if (half_period !== 8'd5) $display("FAIL stall_hold_hp: got %0d, required 5", half_period); else passed++;
      sig_in = ~sig_in;
      tick(4);
      total++; if (timeout !== 1'b0) $display("FAIL stall_clear: got %0b, required 0", timeout); else passed++;
      toggle_after(1); push_exp(5, 1'b0);
      tick(6);
      total++; if (sb.size() != 0) $display("FAIL stall_pending: got %0d outstanding, required 0", sb.size()); else passed++;
   endtask

   task automatic test_boundary;
      do_reset();
      toggle_after(2);
      toggle_after(20); push_exp(20, 1'b0);
      tick(4);
      total++; if (timeout !== 1'b0) $display("FAIL bound_20_timeout: got %0b, required 0", timeout); else passed++;
      toggle_after(17);
      tick(2);
      total++; if (timeout !== 1'b1) $display("FAIL bound_21_timeout: got %0b, required 1", timeout); else passed++;
      tick(1);
      total++; if (timeout !== 1'b0) $display("FAIL bound_21_clear: got %0b, required 0", timeout); else passed++;
      toggle_after(2); push_exp(5, 1'b0);
      tick(6);
      total++; if (sb.size() != 0) $display("FAIL bound_pending: got %0d outstanding, required 0", sb.size()); else passed++;
   endtask

   task automatic test_reset_mid;
      do_reset();
      toggle_after(2);
      toggle_after(5); push_exp(5, 1'b0);
      tick(6);
      rst_n = 1'b0;
      tick(1);
      total++; if (half_period !== 8'd0) $display("FAIL mid_rst_half_period: got %0d, required 0", half_period); else passed++;
      total++; if (locked !== 1'b0) $display("FAIL mid_rst_locked: got %0b, required 0", locked); else passed++;
      total++; if (timeout !== 1'b0) $display("FAIL mid_rst_timeout: got %0b, required 0", timeout); else passed++;
      rst_n = 1'b1;
      toggle_after(3);
      toggle_after(7); push_exp(7, 1'b0);
      tick(6);
      total++; if (sb.size() != 0) $display("FAIL mid_pending: got %0d outstanding, required 0", sb.size()); else passed++;
   endtask

   initial begin
      test_reset();
      test_steady();
      test_jitter();
      test_stall();
      test_boundary();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
